// File: rtl/edit_field_ctrl.sv
// rtl/edit_field_ctrl.sv - front-panel edit controller: field select, step pulses with auto-repeat, timeout, blink
module edit_field_ctrl #(
    parameter int TICK_DIV   = 100000,
    parameter int HOLD_MS    = 500,
    parameter int RPT_MS     = 250,
    parameter int TIMEOUT_MS = 10000,
    parameter int BLINK_MS   = 250,
    parameter int N_FIELDS   = 6
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       btn_mode,
    input  logic       btn_left,
    input  logic       btn_right,
    input  logic       btn_up,
    input  logic       btn_down,
    output logic [3:0] en_count,
    output logic       enUP,
    output logic       enDOWN,
    output logic       edit_active,
    output logic       blink
);
    localparam int PW   = $clog2(TICK_DIV + 1);
    localparam int HMAX = (HOLD_MS > RPT_MS) ? HOLD_MS : RPT_MS;
    localparam int HW   = $clog2(HMAX + 1);
    localparam int TW   = $clog2(TIMEOUT_MS + 1);
    localparam int BW   = $clog2(BLINK_MS + 1);

    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_EDIT = 1'b1;
    localparam logic [1:0] K_IDLE  = 2'd0;
    localparam logic [1:0] K_HOLD  = 2'd1;
    localparam logic [1:0] K_RPT   = 2'd2;
    localparam logic [1:0] K_LOCK  = 2'd3;

    logic [PW-1:0] presc_q, presc_d;
    logic [0:0]    mode_q, mode_d;
    logic [3:0]    field_q, field_d;
    logic          blink_q, blink_d;
    logic [BW-1:0] bcnt_q, bcnt_d;
    logic [TW-1:0] tcnt_q, tcnt_d;
    logic [1:0]    key_q, key_d;
    logic          dir_q, dir_d;
    logic [HW-1:0] hcnt_q, hcnt_d;
    logic          up_q, up_d, dn_q, dn_d;
    logic          mode_btn_q, left_btn_q, right_btn_q;

    logic          tick, rise_mode, rise_left, rise_right;
    logic          req_up, req_dn, req, activity, enter, leave, step;
    logic [HW-1:0] hlast;

    always_comb begin
        tick       = (presc_q == PW'(TICK_DIV - 1));
        presc_d    = tick ? '0 : presc_q + 1'b1;
        rise_mode  = btn_mode & ~mode_btn_q;
        rise_left  = btn_left & ~left_btn_q;
        rise_right = btn_right & ~right_btn_q;
        req_up     = btn_up & ~btn_down;
        req_dn     = btn_down & ~btn_up;
        req        = req_up | req_dn;
        activity   = rise_mode | rise_left | rise_right | btn_up | btn_down;
        hlast      = (key_q == K_HOLD) ? HW'(HOLD_MS - 1) : HW'(RPT_MS - 1);
        enter      = (mode_q == ST_IDLE) && rise_mode;
        leave      = (mode_q == ST_EDIT) &&
                     (rise_mode || (!activity && tick && tcnt_q == TW'(TIMEOUT_MS - 1)));

        mode_d  = mode_q;
        field_d = field_q;
        blink_d = blink_q;
        bcnt_d  = bcnt_q;
        tcnt_d  = tcnt_q;
        key_d   = key_q;
        dir_d   = dir_q;
        hcnt_d  = hcnt_q;
        step    = 1'b0;

        // IDLE, entry and exit all park every counter and the key FSM
        if (mode_q == ST_IDLE || leave) begin
            mode_d  = enter ? ST_EDIT : ST_IDLE;
            field_d = enter ? 4'd1 : 4'd0;
            blink_d = enter;
            bcnt_d  = '0;
            tcnt_d  = '0;
            hcnt_d  = '0;
            key_d   = K_IDLE;
        end else begin
            tcnt_d = activity ? '0 : tcnt_q + TW'(tick);
            if (tick) begin
                if (bcnt_q == BW'(BLINK_MS - 1)) begin
                    bcnt_d  = '0;
                    blink_d = ~blink_q;
                end else begin
                    bcnt_d = bcnt_q + 1'b1;
                end
            end
            if (rise_left != rise_right) begin
                if (rise_right) field_d = (field_q == 4'(N_FIELDS)) ? 4'd1 : field_q + 4'd1;
                else            field_d = (field_q == 4'd1) ? 4'(N_FIELDS) : field_q - 4'd1;
                blink_d = 1'b1;
                bcnt_d  = '0;
                key_d   = K_LOCK;
            end else begin
                case (key_q)
                    K_IDLE: begin
                        if (req) begin
                            step   = 1'b1;
                            hcnt_d = '0;
                            dir_d  = req_dn;
                            key_d  = K_HOLD;
                        end
                    end
                    K_HOLD, K_RPT: begin
                        if (!req || req_dn != dir_q) begin
                            key_d = K_IDLE;
                        end else if (tick) begin
                            if (hcnt_q == hlast) begin
                                step   = 1'b1;
                                hcnt_d = '0;
                                key_d  = K_RPT;
                            end else begin
                                hcnt_d = hcnt_q + 1'b1;
                            end
                        end
                    end
                    default: begin
                        if (!btn_up && !btn_down) key_d = K_IDLE;
                    end
                endcase
            end
        end

        up_d = step & ~dir_d;
        dn_d = step & dir_d;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            presc_q     <= '0;
            mode_q      <= ST_IDLE;
            field_q     <= 4'd0;
            blink_q     <= 1'b0;
            bcnt_q      <= '0;
            tcnt_q      <= '0;
            key_q       <= K_IDLE;
            dir_q       <= 1'b0;
            hcnt_q      <= '0;
            up_q        <= 1'b0;
            dn_q        <= 1'b0;
            mode_btn_q  <= 1'b0;
            left_btn_q  <= 1'b0;
            right_btn_q <= 1'b0;
        end else begin
            presc_q     <= presc_d;
            mode_q      <= mode_d;
            field_q     <= field_d;
            blink_q     <= blink_d;
            bcnt_q      <= bcnt_d;
            tcnt_q      <= tcnt_d;
            key_q       <= key_d;
            dir_q       <= dir_d;
            hcnt_q      <= hcnt_d;
            up_q        <= up_d;
            dn_q        <= dn_d;
            mode_btn_q  <= btn_mode;
            left_btn_q  <= btn_left;
            right_btn_q <= btn_right;
        end
    end

    assign en_count    = field_q;
    assign enUP        = up_q;
    assign enDOWN      = dn_q;
    assign edit_active = (mode_q == ST_EDIT);
    assign blink       = blink_q;

endmodule

// File: doc/edit_field_ctrl.md
Name: edit_field_ctrl

Overview:
- Front-panel edit controller for the RTC time/date counters.
- Converts debounced push-buttons into a field-select code (en_count) and single-cycle enUP/enDOWN step pulses, with hold-to-auto-repeat.
- Adds an inactivity timeout and a blink flag for the display of the field being edited.
- Drives en_count/enUP/enDOWN of every 2-digit field counter; each counter acts only when en_count equals its own code.

Parameters:
TICK_DIV, 100000, clk cycles per time-base tick (1 ms at 100 MHz)
HOLD_MS, 500, ticks a key is held before auto-repeat starts
RPT_MS, 250, ticks between auto-repeat pulses
TIMEOUT_MS, 10000, idle ticks in EDIT before forced return to IDLE
BLINK_MS, 250, ticks per blink half-period
N_FIELDS, 6, number of editable fields (codes 1..N_FIELDS)

Ports:
clk  in  1  system clock
reset  in  1  asynchronous, active-low reset
btn_mode  in  1  enter/leave edit (debounced, clk-synchronous level)
btn_left  in  1  previous field
btn_right  in  1  next field
btn_up  in  1  increment request
btn_down  in  1  decrement request
en_count  out  4  field select: 0 = none, 1 = seconds, 2 = minutes, 3 = hours, 4 = day, 5 = month, 6 = year
enUP  out  1  one-cycle increment pulse
enDOWN  out  1  one-cycle decrement pulse
edit_active  out  1  high while in EDIT
blink  out  1  display blank/show flag for the selected field

Behaviour:
- Reset (reset=0, asynchronous): en_count=0, enUP=0, enDOWN=0, edit_active=0, blink=0; prescaler, hold, timeout and blink counters=0; states IDLE/K_IDLE; edge-detect registers=0.
- All outputs are registered. An input seen high at clk edge n produces its effect on outputs after edge n (latency 1).
- Edge detection: rise_x = btn_x & ~btn_x_q, applied to mode, left and right.
- Time base: prescaler counts 0..TICK_DIV-1; tick is 1 for one cycle at TICK_DIV-1. Free-running from reset.
- Mode FSM:
  - IDLE: en_count=0, edit_active=0, blink=0. rise_mode -> EDIT, en_count=1, blink=1, blink counter cleared.
  - EDIT, rise_right only: en_count = (en_count==N_FIELDS) ? 1 : en_count+1.
  - EDIT, rise_left only: en_count = (en_count==1) ? N_FIELDS : en_count-1.
  - EDIT, rise_left and rise_right in the same cycle: no change.
  - Any field change sets blink=1, clears the blink counter and forces key FSM -> K_LOCK.
  - EDIT, rise_mode -> IDLE. rise_mode has priority over left/right in the same cycle.
  - Timeout counter (ticks) clears on any rise_*, on any btn_up/btn_down high, and on every step pulse. Reaching TIMEOUT_MS -> IDLE.
  - Leaving EDIT forces K_IDLE. No enUP/enDOWN is issued in the exit cycle.
- Key FSM (runs only in EDIT; held at K_IDLE in IDLE):
  - req_up = btn_up & ~btn_down; req_dn = btn_down & ~btn_up. Both high or both low = no request.
  - K_IDLE: on a request, pulse enUP or enDOWN for 1 cycle, clear the hold counter -> K_HOLD.
  - K_HOLD: if the request drops or its direction changes -> K_IDLE with no pulse; a new request is serviced from K_IDLE on the next cycle. Otherwise count ticks; at HOLD_MS, pulse and clear -> K_RPT.
  - K_RPT: pulse every RPT_MS ticks while the same request persists; drop or direction change -> K_IDLE.
  - K_LOCK: no pulses until btn_up=0 and btn_down=0 -> K_IDLE.
- enUP and enDOWN are mutually exclusive and never high for 2 consecutive cycles. Downstream field counters sample them on clk.
- Blink: in EDIT, toggles every BLINK_MS ticks. Forced to 0 in IDLE.
- Wrap-around of field values (59->0, etc.) is owned by the field counters, not by this block.

Test Plan:
Use TICK_DIV=4, HOLD_MS=5, RPT_MS=2, TIMEOUT_MS=20, BLINK_MS=3 for all scenarios.
1. Release reset with all buttons 0 -> en_count=0, edit_active=0, blink=0. Assert reset mid-EDIT with btn_up held -> all outputs 0 immediately, without waiting for a clk edge.
2. Pulse btn_mode, then btn_right 6 times -> en_count 1,2,3,4,5,6,1. Then btn_left once -> 6. btn_left and btn_right rising together -> unchanged.
3. In EDIT, press btn_up for 3 ticks -> exactly 1 enUP pulse. Hold for 13 ticks -> pulses at press, tick 5, tick 7, tick 9, tick 11, tick 13 (6 total). enDOWN stays 0.
4. Hold btn_up and btn_down together -> no pulses. Hold btn_up, then switch to btn_down only -> enUP stops; one enDOWN pulse follows 2 cycles after the switch.
5. Hold btn_up in K_RPT and pulse btn_right -> en_count+1, no further pulses until btn_up is released. Re-press -> 1 pulse.
6. Enter EDIT with no activity -> blink toggles every 3 ticks. After 20 ticks -> IDLE, en_count=0, blink=0. btn_mode together with btn_right in EDIT -> IDLE, en_count unchanged before the exit.
